// File: rtl/fetch_unit.sv
// Fetch unit: PC sequencer, one-cycle imem read, credit-based fetch FIFO.
// Define FETCH_JMP_REL_EN for PC-relative redirects; absolute otherwise.
module fetch_unit #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jmp,
  input  logic [PC_WIDTH-1:0]    jmp_target,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    redir;
  logic                   infl_q;
  logic [PC_WIDTH-1:0]    infl_pc_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [INSTR_WIDTH-1:0] instr_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    tag_q   [FIFO_DEPTH];

  logic issue, wr_en, rd_en, nonempty;
  logic [CW-1:0] credit;

`ifdef FETCH_JMP_REL_EN
  assign redir = pc_q + jmp_target;
`else
  assign redir = jmp_target;
`endif

  // Credits cover buffered entries plus the response still on the bus
  assign credit   = count_q + CW'(infl_q);
  assign issue    = ~rst & ~jmp & (credit < DEPTH_C);
  assign nonempty = (count_q != '0);
  assign wr_en    = infl_q & ~jmp & ~rst;
  assign rd_en    = nonempty & out_ready & ~jmp;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
    if (jmp) begin
      pc_d    = redir;
      count_d = '0;
    end else if (issue) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      infl_q  <= issue;
      count_q <= count_d;
      if (issue) infl_pc_q <= pc_q;
      if (jmp) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_q[wr_ptr_q] <= imem_data;
      tag_q[wr_ptr_q]   <= infl_pc_q;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = rst ? '0 : pc_q;
  assign out_valid = ~rst & nonempty;
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule
